// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment scan driver.
//   SEG_OFF    : segment byte with every segment (and dp) dark, active-low.
//   SEG_TABLE  : hex nibble -> active-low segment byte, bit 7 = dp (off),
//                bits 6:0 = g..a. Element n is the pattern for nibble n.
//   hex_to_seg : table lookup helper.
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Packed array: the leftmost entry is index 15 (nibble F).
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the display data path of the scan driver.
//   load        : strobe requesting capture of value/dp_in/blank
//   value       : 4*NUM_DIGITS hex nibbles, nibble i feeds digit i
//   dp_in       : per-digit decimal point request, 1 = lit
//   blank       : per-digit force-off, 1 = dark
//   seg_n       : active-low segments, bit 7 = dp, bits 6:0 = g..a
//   an_n        : active-low digit enables, at most one low
//   frame_start : one-cycle pulse when scanning restarts at digit 0
// Modports: master = data source / display consumer, slave = the driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic [7:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_start;

    modport master (
        output load, value, dp_in, blank,
        input  seg_n, an_n, frame_start
    );

    modport slave (
        input  load, value, dp_in, blank,
        output seg_n, an_n, frame_start
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational nibble-to-segment encoder.
//   nibble : hex digit to show
//   dp     : decimal point request, 1 = lit
//   seg    : active-low segment byte, bit 7 = dp, bits 6:0 = g..a
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);
    logic [7:0] pattern;

    always_comb begin
        pattern = hex_to_seg(nibble);
        // Table bytes carry dp off; the live dp replaces bit 7.
        seg     = {~dp, pattern[6:0]};
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a common-anode seven-segment display.
// A prescaler sets how long each digit stays lit; the digit index walks
// 0..NUM_DIGITS-1. Display data is taken from a shadow register that only
// changes at the frame wrap, so a frame never mixes old and new data.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : seg7_scan_driver_if.slave (load/value/dp_in/blank in,
//           seg_n/an_n/frame_start out)
// Parameters: NUM_DIGITS (1..8), REFRESH_DIV (>= 2, clk cycles per digit).
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to darken digits above the
// highest nonzero shadow nibble (digit 0 is always shown).
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

    // Scan timing
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tick;
    logic             wrap;

    // Shadow (displayed) and pending (waiting for wrap) data
    logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [4*NUM_DIGITS-1:0] pd_value_q, pd_value_d;
    logic [NUM_DIGITS-1:0]   pd_dp_q, pd_dp_d;
    logic [NUM_DIGITS-1:0]   pd_blank_q, pd_blank_d;
    logic                    pend_q, pend_d;

    // Registered outputs
    logic [7:0]            seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  frame_q;

    // Active-digit selection
    logic [3:0]            act_nibble;
    logic                  act_dp;
    logic                  act_blank;
    logic [NUM_DIGITS-1:0] act_onehot;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [7:0]            act_seg;

    // ---------------------------------------------------------------------
    // Prescaler and digit index
    // ---------------------------------------------------------------------
    always_comb begin
        tick  = (cnt_q == LAST_CNT);
        wrap  = tick && (idx_q == LAST_IDX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (wrap) begin
            idx_d = '0;
        end else if (tick) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Load handling: loads park in the pending register and are promoted at
    // the wrap. A load landing on the wrap itself goes straight to shadow and
    // supersedes anything pending, keeping "last load wins".
    // ---------------------------------------------------------------------
    always_comb begin
        sh_value_d = sh_value_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        pd_value_d = pd_value_q;
        pd_dp_d    = pd_dp_q;
        pd_blank_d = pd_blank_q;
        pend_d     = pend_q;

        if (wrap) begin
            if (bus.load) begin
                sh_value_d = bus.value;
                sh_dp_d    = bus.dp_in;
                sh_blank_d = bus.blank;
            end else if (pend_q) begin
                sh_value_d = pd_value_q;
                sh_dp_d    = pd_dp_q;
                sh_blank_d = pd_blank_q;
            end
            pend_d = 1'b0;
        end else if (bus.load) begin
            pd_value_d = bus.value;
            pd_dp_d    = bus.dp_in;
            pd_blank_d = bus.blank;
            pend_d     = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Leading-zero suppression
    // ---------------------------------------------------------------------
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic seen_nonzero;
        lz_blank     = '0;
        seen_nonzero = 1'b0;
        // Walk from the top digit down; everything above the first nonzero
        // nibble is dark. Digit 0 is excluded so a zero value still shows "0".
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            if (sh_value_q[4*i +: 4] != 4'h0) begin
                seen_nonzero = 1'b1;
            end
            lz_blank[i] = ~seen_nonzero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // ---------------------------------------------------------------------
    // Active digit mux
    // ---------------------------------------------------------------------
    always_comb begin
        act_nibble = 4'h0;
        act_dp     = 1'b0;
        act_blank  = 1'b0;
        act_onehot = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                act_nibble    = sh_value_q[4*i +: 4];
                act_dp        = sh_dp_q[i];
                act_blank     = sh_blank_q[i] | lz_blank[i];
                act_onehot[i] = 1'b1;
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (act_nibble),
        .dp     (act_dp),
        .seg    (act_seg)
    );

    always_comb begin
        seg_n_d = SEG_OFF;
        an_n_d  = '1;
        if (!act_blank) begin
            seg_n_d = act_seg;
            an_n_d  = ~act_onehot;
        end
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_value_q <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            pd_value_q <= '0;
            pd_dp_q    <= '0;
            pd_blank_q <= '0;
            pend_q     <= 1'b0;
            seg_n_q    <= SEG_OFF;
            an_n_q     <= '1;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_value_q <= sh_value_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            pd_value_q <= pd_value_d;
            pd_dp_q    <= pd_dp_d;
            pd_blank_q <= pd_blank_d;
            pend_q     <= pend_d;
            seg_n_q    <= seg_n_d;
            an_n_q     <= an_n_d;
            // Registered so the pulse lines up with idx returning to 0.
            frame_q    <= wrap;
        end
    end

    assign bus.seg_n       = seg_n_q;
    assign bus.an_n        = an_n_q;
    assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4 (16-cycle frame).
// A time-based model (edges since reset release) predicts every output cycle;
// directed checks with literal values pin the model.
// Honours SEG7_LEADING_ZERO_BLANK_EN the same way the design build does.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;
    localparam int N  = 4;
    localparam int R  = 4;
    localparam int FR = N * R;

    localparam logic [7:0] HEX_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    localparam logic [3:0] SLOT_AN [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [7:0] SEG_1A3F [4] = '{8'h8E, 8'hB0, 8'h88, 8'hF9};

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model
    // ------------------------------------------------------------------
    int         k = 0;
    logic [15:0] m_val = '0, p_val = '0;
    logic [3:0]  m_dp = '0, m_blk = '0, p_dp = '0, p_blk = '0;
    bit          p_vld = 1'b0;
    logic [3:0]  exp_an  = 4'hF;
    logic [7:0]  exp_seg = 8'hFF;
    logic        exp_fs  = 1'b0;

    function automatic logic [3:0] lz_mask(input logic [15:0] v);
        logic [3:0] m;
        int hi;
        m  = '0;
        hi = 0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int i = 0; i < N; i++) if (v[4*i +: 4] != 4'h0) hi = i;
        for (int i = 0; i < N; i++) m[i] = (i > hi);
`else
        hi = N;
`endif
        return m;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            k = 0; m_val = '0; m_dp = '0; m_blk = '0;
            p_val = '0; p_dp = '0; p_blk = '0; p_vld = 1'b0;
            exp_an = 4'hF; exp_seg = 8'hFF; exp_fs = 1'b0;
        end else begin
            int slot;
            logic [3:0] lz;
            k    = k + 1;
            slot = ((k - 1) / R) % N;
            lz   = lz_mask(m_val);
            if (m_blk[slot] || lz[slot]) begin
                exp_an  = 4'hF;
                exp_seg = 8'hFF;
            end else begin
                exp_an  = ~(4'b0001 << slot);
                exp_seg = {~m_dp[slot], HEX_TAB[m_val[4*slot +: 4]][6:0]};
            end
            exp_fs = (k % FR == 0);
            if (k % FR == 0) begin
                if (bus.load) begin
                    m_val = bus.value; m_dp = bus.dp_in; m_blk = bus.blank;
                end else if (p_vld) begin
                    m_val = p_val; m_dp = p_dp; m_blk = p_blk;
                end
                p_vld = 1'b0;
            end else if (bus.load) begin
                p_val = bus.value; p_dp = bus.dp_in; p_blk = bus.blank; p_vld = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        total++;
        if (bus.an_n !== exp_an || bus.seg_n !== exp_seg || bus.frame_start !== exp_fs) begin
            bad++;
            $display("FAIL cycle k=%0d an_n got %h want %h seg_n got %h want %h fs got %b want %b",
                     k, bus.an_n, exp_an, bus.seg_n, exp_seg, bus.frame_start, exp_fs);
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < 40);
        if (!bus.frame_start) check("frame_start_timeout", 16'(bus.frame_start), 16'd1);
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while ((k % FR) != p && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((k % FR) != p) check("phase_timeout", 16'(k % FR), 16'(p));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        bus.value = v;
        bus.dp_in = d;
        bus.blank = b;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        bit held_old, bad_an, bad_dp;
        bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an_n", 16'(bus.an_n), 16'hF);
        check("rst_seg_n", 16'(bus.seg_n), 16'hFF);
        check("rst_frame_start", 16'(bus.frame_start), 16'h0);

        // Release: digit 0 of cleared shadow, then first frame_start 16 cycles in
        rst = 1'b0;
        @(negedge clk);
        n = 1;
        check("first_an_n", 16'(bus.an_n), 16'hE);
        check("first_seg_n", 16'(bus.seg_n), 16'hC0);
        while (!bus.frame_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("first_frame_start_cycle", 16'(n), 16'd16);

        // Mid-frame load of 1A3F: old data held until the next frame_start
        wait_phase(3);
        do_load(16'h1A3F, 4'h0, 4'h0);
        held_old = 1'b1;
        n = 0;
        while (!bus.frame_start && n < 40) begin
            if (bus.seg_n != 8'hC0 && bus.seg_n != 8'hFF) held_old = 1'b0;
            @(negedge clk);
            n++;
        end
        check("midframe_held_old", 16'(held_old), 16'd1);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            check($sformatf("v1A3F_an_n_%0d", j), 16'(bus.an_n), 16'(SLOT_AN[j / 4]));
            check($sformatf("v1A3F_seg_n_%0d", j), 16'(bus.seg_n), 16'(SEG_1A3F[j / 4]));
        end

        // Pending load, then a load on the wrap cycle: wrap load shows this frame
        wait_phase(5);
        do_load(16'h5555, 4'h0, 4'h0);
        wait_phase(15);
        do_load(16'h2B7C, 4'h0, 4'h0);
        check("wrap_load_frame_start", 16'(bus.frame_start), 16'd1);
        @(negedge clk);
        check("wrap_load_an_n", 16'(bus.an_n), 16'hE);
        check("wrap_load_seg_n", 16'(bus.seg_n), 16'hC6);

        // Two mid-frame loads (last wins) with blank=0100, dp=0010
        wait_phase(2);
        do_load(16'hFFFF, 4'hF, 4'h0);
        wait_phase(6);
        do_load(16'h2B7C, 4'b0010, 4'b0100);
        wait_fs();
        bad_an = 1'b0;
        bad_dp = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (bus.an_n == 4'b1011) bad_an = 1'b1;
            if ((bus.seg_n[7] == 1'b0) != (bus.an_n == 4'b1101)) bad_dp = 1'b1;
            if (j == 4) check("dp_digit1_seg_n", 16'(bus.seg_n), 16'h78);
            if (j == 8) check("blank_digit2_seg_n", 16'(bus.seg_n), 16'hFF);
            if (j == 12) check("digit3_seg_n", 16'(bus.seg_n), 16'hA4);
        end
        check("blank_never_1011", 16'(bad_an), 16'd0);
        check("dp_only_digit1", 16'(bad_dp), 16'd0);

        // Leading zeros: 0042
        wait_phase(3);
        do_load(16'h0042, 4'h0, 4'h0);
        wait_fs();
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (j == 1) begin
                check("lz_d0_an_n", 16'(bus.an_n), 16'hE);
                check("lz_d0_seg_n", 16'(bus.seg_n), 16'hA4);
            end
            if (j == 5) begin
                check("lz_d1_an_n", 16'(bus.an_n), 16'hD);
                check("lz_d1_seg_n", 16'(bus.seg_n), 16'h99);
            end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (j == 9)  check("lz_d2_seg_n", 16'({bus.an_n, bus.seg_n}), 16'hFFF);
            if (j == 13) check("lz_d3_seg_n", 16'({bus.an_n, bus.seg_n}), 16'hFFF);
`else
            if (j == 9)  check("lz_d2_seg_n", 16'({bus.an_n, bus.seg_n}), 16'hBC0);
            if (j == 13) check("lz_d3_seg_n", 16'({bus.an_n, bus.seg_n}), 16'h7C0);
`endif
        end

        // Reset mid-slot with a pending load: outputs off at once, load lost
        wait_phase(4);
        do_load(16'h1234, 4'h0, 4'h0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_an_n", 16'(bus.an_n), 16'hF);
        check("midrst_seg_n", 16'(bus.seg_n), 16'hFF);
        check("midrst_frame_start", 16'(bus.frame_start), 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_an_n", 16'(bus.an_n), 16'hE);
        check("postrst_seg_n", 16'(bus.seg_n), 16'hC0);
        wait_fs();
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (j == 4) check("postrst_d1", 16'({bus.an_n, bus.seg_n}), 16'hFFF);
`else
            if (j == 4) check("postrst_d1", 16'({bus.an_n, bus.seg_n}), 16'hDC0);
`endif
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clk cycles each digit is lit (legal >= 2).
REQ-003 SHALL use one clock and an asynchronous, active-high reset, ports listed first below.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port load  input  1  strobe requesting capture of value/dp_in/blank.
REQ-007 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble i feeds digit i (digit 0 = LSN).
REQ-008 SHALL have port dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-009 SHALL have port blank  input  NUM_DIGITS  per-digit force-off, 1 = dark.
REQ-010 SHALL have port seg_n  output  8  active-low segments; bit 7 = dp, bits 6:0 = g..a.
REQ-011 SHALL have port an_n  output  NUM_DIGITS  active-low digit enables, at most one low.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse when scanning restarts at digit 0.

Function
REQ-013 SHALL run a prescaler counting 0..REFRESH_DIV-1, wrapping to 0; terminal count = tick.
REQ-014 SHALL advance digit index idx by 1 on each tick, wrapping NUM_DIGITS-1 -> 0.
REQ-015 SHALL assert frame_start for exactly the cycle in which idx changes from NUM_DIGITS-1 to 0 (NUM_DIGITS=1: every tick).
REQ-016 SHALL hold a shadow copy of value/dp_in/blank; display uses only shadow.
REQ-017 SHALL on load outside the wrap cycle capture inputs into a pending register and set pending flag.
REQ-018 SHALL on the wrap cycle copy pending into shadow if flag set, then clear flag.
REQ-019 SHALL on load coincident with the wrap cycle write inputs directly to shadow and leave flag clear.
REQ-020 SHALL on multiple loads within one frame keep only the most recent (last wins).
REQ-021 SHALL register seg_n and an_n; they reflect idx and shadow with one-cycle latency.
REQ-022 SHALL encode nibbles to seg_n[6:0] as 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,B=83,C=C6,D=A1,E=86,F=8E (hex of full byte, dp off).
REQ-023 SHALL drive seg_n[7] = ~shadow dp of the active digit.
REQ-024 SHALL for a blanked digit drive an_n all ones and seg_n = FF for its whole slot.

Reset
REQ-025 SHALL while rst high hold an_n = all ones, seg_n = FF, frame_start = 0.
REQ-026 SHALL clear prescaler, idx, shadow, pending register and pending flag to 0 on rst.
REQ-027 SHALL on the first edge after rst release drive digit 0 of cleared shadow (an_n bit0 low, seg_n = C0).
REQ-028 SHALL on rst mid-frame discard pending loads and restart scanning from digit 0.

Configuration
REQ-029 SHALL honour macro SEG7_LEADING_ZERO_BLANK_EN.
REQ-030 SHALL with macro defined treat digits above the highest nonzero shadow nibble as blanked; digit 0 never auto-blanked.
REQ-031 SHALL with macro undefined display every non-blanked digit including leading zeros.

Structure
REQ-032 SHALL place the 16-entry segment encoding table and SEG_OFF (FF) constant in shared package seg7_pkg.
REQ-033 SHALL implement nibble-to-segment encode as sub-module seg7_hex_decode (combinational, uses seg7_pkg).

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-034 SHALL check reset: rst high -> an_n=F, seg_n=FF; release -> an_n=E, seg_n=C0, frame_start after 16 cycles.
REQ-035 SHALL check load value=1A3F -> after next frame_start slots show an_n E/D/B/7 with seg_n 8E/B0/88/F9, 4 cycles each.
REQ-036 SHALL check load mid-frame -> displayed digits unchanged until frame_start; load at wrap cycle -> new data same frame.
REQ-037 SHALL check blank=0100, dp_in=0010 -> an_n never 1011; seg_n bit7=0 only while an_n=1101.
REQ-038 SHALL check macro defined, value=0042 -> digits 3 and 2 dark, digit 1 = 99, digit 0 = A4; undefined -> digits 3,2 show C0.
REQ-039 SHALL check rst asserted mid-slot with pending load -> outputs off immediately; after release shadow=0, pending lost.
